// File: rtl/thermostat_mask_pkg.sv
// Shared types and helpers for the two-share masked thermostat codec:
// FSM states, LFSR polynomial, share-pair struct and mask/unmask helpers.
package thermostat_mask_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPT,
    ST_OUT
  } codec_state_e;

  // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef struct packed {
    logic s0;
    logic s1;
  } share_t;

  function automatic share_t mask(input logic x, input logic m);
    share_t p;
    p.s0 = x ^ m;
    p.s1 = m;
    return p;
  endfunction

  function automatic logic unmask(input share_t p);
    return p.s0 ^ p.s1;
  endfunction

endpackage

// File: rtl/thermostat_share_codec_mask_lfsr.sv
// 32-bit Galois LFSR supplying masks and refresh bits; steps only when
// told to, and never runs from an all-zero state.
module mask_lfsr
  import thermostat_mask_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [31:0] state
);

  // An all-zero register would lock the sequence, so a zero seed becomes 1
  localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED_NZ;
    end else if (advance) begin
      state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/thermostat_share_codec.sv
// Plaintext endpoint of the masked thermostat core: splits each request into
// registered Boolean shares, waits out the core, recombines the result.
module thermostat_share_codec
  import thermostat_mask_pkg::*;
#(
  parameter int unsigned CORE_LATENCY = 1,
  parameter logic [31:0] SEED         = 32'hACE1_2024
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic too_cold,
  input  logic too_hot,
  input  logic mode,
  input  logic fan_on,
  output logic out_valid,
  input  logic out_ready,
  output logic heater,
  output logic aircon,
  output logic fan,
  output logic too_cold0,
  output logic too_cold1,
  output logic too_hot0,
  output logic too_hot1,
  output logic mode0,
  output logic mode1,
  output logic fan_on0,
  output logic fan_on1,
  output logic r0,
  output logic r1,
  output logic r2,
  output logic r3,
  input  logic heater0,
  input  logic heater1,
  input  logic aircon0,
  input  logic aircon1,
  input  logic fan0,
  input  logic fan1
);

  localparam int unsigned CNT_W = $clog2(CORE_LATENCY + 1);

  generate
    if (CORE_LATENCY == 0) begin : g_bad_latency
      $error("thermostat_share_codec: CORE_LATENCY must be at least 1");
    end
  endgenerate

  codec_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      lfsr_state;
  logic             accept;

  share_t           cold_p0, hot_p0, mode_p0, fan_on_p0;
  logic   [3:0]     r_p0;
  logic             heater_p1, aircon_p1, fan_p1;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign accept    = in_ready && in_valid;

  mask_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (accept),
    .state   (lfsr_state)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(CORE_LATENCY)) begin
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPT: state_d = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage p0: shares and refresh bits, loaded from the pre-advance LFSR state
  always_ff @(posedge clk) begin
    if (rst) begin
      cold_p0   <= '0;
      hot_p0    <= '0;
      mode_p0   <= '0;
      fan_on_p0 <= '0;
      r_p0      <= '0;
    end else if (accept) begin
      cold_p0   <= mask(too_cold, lfsr_state[3]);
      hot_p0    <= mask(too_hot,  lfsr_state[2]);
      mode_p0   <= mask(mode,     lfsr_state[1]);
      fan_on_p0 <= mask(fan_on,   lfsr_state[0]);
      r_p0      <= lfsr_state[7:4];
    end
  end

  // Stage p1: recombined result, held until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      heater_p1 <= 1'b0;
      aircon_p1 <= 1'b0;
      fan_p1    <= 1'b0;
    end else if (state_q == ST_CAPT) begin
      heater_p1 <= unmask('{s0: heater0, s1: heater1});
      aircon_p1 <= unmask('{s0: aircon0, s1: aircon1});
      fan_p1    <= unmask('{s0: fan0,    s1: fan1});
    end
  end

  assign too_cold0 = cold_p0.s0;
  assign too_cold1 = cold_p0.s1;
  assign too_hot0  = hot_p0.s0;
  assign too_hot1  = hot_p0.s1;
  assign mode0     = mode_p0.s0;
  assign mode1     = mode_p0.s1;
  assign fan_on0   = fan_on_p0.s0;
  assign fan_on1   = fan_on_p0.s1;
  assign {r0, r1, r2, r3} = r_p0;

  assign heater = heater_p1;
  assign aircon = aircon_p1;
  assign fan    = fan_p1;

endmodule

// File: tb/tb_thermostat_share_codec.sv
// Scoreboard bench for thermostat_share_codec with a behavioural masked core;
// a second instance built with SEED=0 runs in lockstep with the SEED=1 one.
module tb_thermostat_share_codec;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready;
  logic too_cold, too_hot, mode, fan_on;

  logic in_ready, out_valid, heater, aircon, fan;
  logic too_cold0, too_cold1, too_hot0, too_hot1, mode0, mode1, fan_on0, fan_on1;
  logic r0, r1, r2, r3;

  logic b_in_ready, b_out_valid, b_heater, b_aircon, b_fan;
  logic b_too_cold0, b_too_cold1, b_too_hot0, b_too_hot1, b_mode0, b_mode1, b_fan_on0, b_fan_on1;
  logic b_r0, b_r1, b_r2, b_r3;

  logic heater0, heater1, aircon0, aircon1, fan0, fan1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [2:0]  exp_q[$];
  logic [31:0] lfsr_m;
  bit          forbid_ov = 0;

  wire [11:0] sh_a = {too_cold0, too_cold1, too_hot0, too_hot1, mode0, mode1,
                      fan_on0, fan_on1, r0, r1, r2, r3};
  wire [11:0] sh_b = {b_too_cold0, b_too_cold1, b_too_hot0, b_too_hot1, b_mode0, b_mode1,
                      b_fan_on0, b_fan_on1, b_r0, b_r1, b_r2, b_r3};

  always #5 clk = ~clk;

  thermostat_share_codec #(.CORE_LATENCY(1), .SEED(32'h1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .too_cold(too_cold), .too_hot(too_hot), .mode(mode), .fan_on(fan_on),
    .out_valid(out_valid), .out_ready(out_ready),
    .heater(heater), .aircon(aircon), .fan(fan),
    .too_cold0(too_cold0), .too_cold1(too_cold1), .too_hot0(too_hot0), .too_hot1(too_hot1),
    .mode0(mode0), .mode1(mode1), .fan_on0(fan_on0), .fan_on1(fan_on1),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .heater0(heater0), .heater1(heater1), .aircon0(aircon0), .aircon1(aircon1),
    .fan0(fan0), .fan1(fan1)
  );

  thermostat_share_codec #(.CORE_LATENCY(1), .SEED(32'h0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .too_cold(too_cold), .too_hot(too_hot), .mode(mode), .fan_on(fan_on),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .heater(b_heater), .aircon(b_aircon), .fan(b_fan),
    .too_cold0(b_too_cold0), .too_cold1(b_too_cold1), .too_hot0(b_too_hot0), .too_hot1(b_too_hot1),
    .mode0(b_mode0), .mode1(b_mode1), .fan_on0(b_fan_on0), .fan_on1(b_fan_on1),
    .r0(b_r0), .r1(b_r1), .r2(b_r2), .r3(b_r3),
    .heater0(heater0), .heater1(heater1), .aircon0(aircon0), .aircon1(aircon1),
    .fan0(fan0), .fan1(fan1)
  );

  // p = {too_cold, too_hot, mode, fan_on}; result = {heater, aircon, fan}
  function automatic logic [2:0] golden(input logic [3:0] p);
    logic heat, cool;
    heat = p[3] & p[1];
    cool = p[2] & ~p[1];
    return {heat, cool, p[0] | heat | cool};
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[31] = ~n[31];
      n[21] = ~n[21];
      n[1]  = ~n[1];
      n[0]  = ~n[0];
    end
    return n;
  endfunction

  // Behavioural masked core: one output register, output shares refreshed by r
  always @(posedge clk) begin
    logic [2:0] g;
    g = golden({too_cold0 ^ too_cold1, too_hot0 ^ too_hot1, mode0 ^ mode1, fan_on0 ^ fan_on1});
    heater0 <= g[2] ^ r0;        heater1 <= r0;
    aircon0 <= g[1] ^ r1;        aircon1 <= r1;
    fan0    <= g[0] ^ (r2 ^ r3); fan1    <= r2 ^ r3;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h", tag, obs, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_output", 1, 0);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        check_eq("result", {heater, aircon, fan}, e);
        check_eq("result_seed0", {b_heater, b_aircon, b_fan}, e);
      end
    end
    if (forbid_ov && (out_valid || b_out_valid))
      check_eq("out_valid_after_rst", {out_valid, b_out_valid}, 0);
  end

  // Called and returns at #1 after a rising edge
  task automatic do_req(input logic [3:0] p);
    bit acc;
    acc = 0;
    {too_cold, too_hot, mode, fan_on} = p;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      check_eq("accept_timeout", 0, 1);
      return;
    end
    exp_q.push_back(golden(p));
    check_eq("share1", {too_cold1, too_hot1, mode1, fan_on1}, lfsr_m[3:0]);
    check_eq("share0", {too_cold0, too_hot0, mode0, fan_on0}, p ^ lfsr_m[3:0]);
    check_eq("refresh", {r0, r1, r2, r3}, lfsr_m[7:4]);
    check_eq("shares_seed0", sh_b, sh_a);
    lfsr_m = lfsr_next(lfsr_m);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    logic [11:0] snap;
    logic [15:0] seen;
    logic [3:0]  nib;
    logic [3:0]  p;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    {too_cold, too_hot, mode, fan_on} = 4'b1111;
    lfsr_m = 32'h1;

    // Reset, with in_valid held high and ignored
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outputs", {out_valid, heater, aircon, fan}, 0);
    check_eq("rst_in_ready", {in_ready, b_in_ready}, 2'b11);
    check_eq("rst_shares", sh_a, 0);
    check_eq("rst_shares_seed0", sh_b, 0);
    rst = 1'b0; in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("idle_shares", sh_a, 0);
    check_eq("idle_in_ready", in_ready, 1);

    // Single request: cold, heat mode
    do_req(4'b1010);
    check_eq("cold_recombine", too_cold0 ^ too_cold1, 1);
    snap = sh_a;
    @(posedge clk); #1;
    check_eq("ov_t1", out_valid, 0);
    check_eq("shares_hold", sh_a, snap);
    @(posedge clk); #1;
    check_eq("ov_t2", out_valid, 0);
    @(posedge clk); #1;
    check_eq("ov_t3", out_valid, 1);
    check_eq("result_t3", {heater, aircon, fan}, 3'b101);
    wait_drain();

    // Backpressure
    out_ready = 1'b0;
    do_req(4'b0100);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check_eq("bp_ov_rise", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      {too_cold, too_hot, mode, fan_on} = 4'($urandom);
      @(posedge clk); #1;
      check_eq("bp_hold", {out_valid, in_ready, heater, aircon, fan}, 5'b10011);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Mask freshness with constant plaintext
    seen = '0;
    for (int i = 0; i < 64; i++) begin
      do_req(4'b0101);
      nib = {too_cold1, too_hot1, mode1, fan_on1};
      seen[nib] = 1'b1;
    end
    wait_drain();
    check_eq("mask_varies", ($countones(seen) > 1), 1);

    // Reset while waiting on the core
    do_req(4'b1110);
    @(posedge clk); #1;
    rst = 1'b1;
    forbid_ov = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    lfsr_m = 32'h1;
    repeat (6) @(posedge clk);
    #1;
    forbid_ov = 0;
    check_eq("post_rst_in_ready", in_ready, 1);
    check_eq("post_rst_shares", sh_a, 0);
    do_req(4'b0011);
    wait_drain();

    // Long random run; the SEED=0 instance must never stick at zero
    for (int i = 0; i < 1000; i++) begin
      p = 4'($urandom_range(0, 15));
      do_req(p);
      if (i % 100 == 99) check_eq("lfsr_nonzero", (dut_b.u_lfsr.state != 32'h0), 1);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
